// File: rtl/max_exp_align_sched.sv
// Exponent-alignment scheduler: loads one N-element window of exponents, tracks
// the maximum, then replays per-element right-shift amounts to the aligners.

module max_exp_align_slot #(
  parameter int EXP_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [EXP_W-1:0] d_exp,
  input  logic             d_skip,
  output logic [EXP_W-1:0] exp_q,
  output logic             skip_q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      skip_q <= 1'b0;
    end else if (ld) begin
      exp_q  <= d_exp;
      skip_q <= d_skip;
    end
  end
endmodule

module max_exp_align_sched #(
  parameter int EXP_W = 6,
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_skip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_shift,
  output logic             out_skip,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [EXP_W-1:0] out_max
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N-1);

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  typedef struct packed {
    logic [EXP_W-1:0] shift;
    logic             skip;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [EXP_W-1:0] max;
  } rec_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [EXP_W-1:0]        max_q, max_d;
  logic [N-1:0][EXP_W-1:0] ebuf;
  logic [N-1:0]            sbuf, slot_ld;
  logic [EXP_W-1:0]        eff;
  logic                    emit, at_last, in_hs, out_hs;
  rec_t                    rec;

  assign eff     = in_skip ? '0 : in_exp;
  assign emit    = (state_q == EMIT);
  assign at_last = (cnt_q == LAST);
  assign in_hs   = in_valid & ~emit;
  assign out_hs  = out_ready & emit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    if (abort) begin
      state_d = LOAD;
      cnt_d   = '0;
      max_d   = '0;
    end else if (in_hs) begin
      max_d = (eff > max_q) ? eff : max_q;
      if (at_last) begin
        state_d = EMIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_hs) begin
      if (at_last) begin
        state_d = LOAD;
        cnt_d   = '0;
        max_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
    end
  end

  // One storage slot per window element; an aborted handshake never loads.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot_ld[i] = in_hs & ~abort & (cnt_q == IDX_W'(i));
    max_exp_align_slot #(.EXP_W(EXP_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld     (slot_ld[i]),
      .d_exp  (eff),
      .d_skip (in_skip),
      .exp_q  (ebuf[i]),
      .skip_q (sbuf[i])
    );
  end

  // max_q dominates every stored entry, so the subtraction cannot wrap.
  always_comb begin
    rec = '0;
    if (emit) begin
      rec.shift = max_q - ebuf[cnt_q];
      rec.skip  = sbuf[cnt_q];
      rec.idx   = cnt_q;
      rec.last  = at_last;
      rec.max   = max_q;
    end
  end

  assign in_ready  = ~emit;
  assign out_valid = emit;
  assign out_shift = rec.shift;
  assign out_skip  = rec.skip;
  assign out_idx   = rec.idx;
  assign out_last  = rec.last;
  assign out_max   = rec.max;
endmodule

// File: tb/tb_max_exp_align_sched.sv
// Bench for max_exp_align_sched: directed vector table, abort/reset sequences,
// and random windows checked against a plain max/subtract reference model.

module tb_max_exp_align_sched;
  localparam int EXP_W = 6;
  localparam int N     = 9;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [EXP_W-1:0] in_exp = '0;
  logic             in_skip = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [EXP_W-1:0] out_shift;
  logic             out_skip;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic [EXP_W-1:0] out_max;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  max_exp_align_sched #(.EXP_W(EXP_W), .N(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_skip   (in_skip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_shift (out_shift),
    .out_skip  (out_skip),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_max   (out_max)
  );

  typedef struct packed {
    logic [N-1:0][EXP_W-1:0] exps;
    logic [N-1:0]            skip;
    logic [EXP_W-1:0]        emax;
    logic [N-1:0][EXP_W-1:0] shifts;
    logic [1:0]              rmode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: max over effective exponents, shift is the distance to that max.
  function automatic vec_t model(input logic [N-1:0][EXP_W-1:0] exps, input logic [N-1:0] skip,
                                 input logic [1:0] rmode);
    vec_t v;
    int   m = 0;
    int   e[N];
    for (int i = 0; i < N; i++) begin
      e[i] = skip[i] ? 0 : int'(exps[i]);
      if (e[i] > m) m = e[i];
    end
    v.exps  = exps;
    v.skip  = skip;
    v.rmode = rmode;
    v.emax  = EXP_W'(m);
    for (int i = 0; i < N; i++) v.shifts[i] = EXP_W'(m - e[i]);
    return v;
  endfunction

  // Leaves the last element driven just before the accepting edge.
  task automatic send_window(input vec_t v, input bit gaps);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_exp   = v.exps[i];
      in_skip  = v.skip[i];
      chk("in_ready_load", 32'(in_ready), 1);
    end
  endtask

  task automatic collect_window(input vec_t v);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < N && cyc < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      case (v.rmode)
        2'd0:    rdy = 1'b1;
        2'd1:    rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      chk("out_valid", 32'(out_valid), 1);
      chk("in_ready_emit", 32'(in_ready), 0);
      chk("out_idx", 32'(out_idx), 32'(idx));
      chk("out_shift", 32'(out_shift), 32'(v.shifts[idx]));
      chk("out_skip", 32'(out_skip), 32'(v.skip[idx]));
      chk("out_last", 32'(out_last), 32'(idx == N-1));
      chk("out_max", 32'(out_max), 32'(v.emax));
      if (rdy) idx++;
      cyc++;
    end
    chk("emit_budget", 32'(idx), N);
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_to_load_valid", 32'(out_valid), 0);
    chk("back_to_load_ready", 32'(in_ready), 1);
    chk("load_out_max", 32'(out_max), 0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [N-1:0][EXP_W-1:0] ex;
    int e1[N] = '{3, 7, 1, 15, 15, 2, 0, 9, 4};
    int s1[N] = '{12, 8, 14, 0, 0, 13, 15, 6, 11};

    // Directed table
    for (int i = 0; i < N; i++) ex[i] = EXP_W'(e1[i]);
    v.exps = ex; v.skip = '0; v.emax = 6'd15; v.rmode = 2'd0;
    for (int i = 0; i < N; i++) v.shifts[i] = EXP_W'(s1[i]);
    tbl.push_back(v);
    v.skip = 9'b000001000; v.shifts[3] = 6'd15;
    tbl.push_back(v);
    v.skip = '1; v.emax = 6'd0; v.shifts = '0;
    tbl.push_back(v);
    for (int i = 0; i < N; i++) v.shifts[i] = EXP_W'(s1[i]);
    v.skip = '0; v.emax = 6'd15; v.rmode = 2'd1;
    tbl.push_back(v);
    for (int i = 0; i < N; i++) v.exps[i] = 6'd63;
    v.emax = 6'd63; v.shifts = '0; v.rmode = 2'd0;
    tbl.push_back(v);
    for (int i = 0; i < N; i++) v.exps[i] = 6'(i == 6 ? 63 : 0);
    v.emax = 6'd63; v.rmode = 2'd0;
    for (int i = 0; i < N; i++) v.shifts[i] = 6'(i == 6 ? 0 : 63);
    tbl.push_back(v);

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_shift", 32'(out_shift), 0);
    chk("rst_out_skip", 32'(out_skip), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_max", 32'(out_max), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      send_window(tbl[k], 1'b0);
      collect_window(tbl[k]);
    end

    // Abort after 5 elements; an element offered alongside abort is dropped
    for (int i = 0; i < N; i++) ex[i] = 6'd20;
    v = model(ex, '0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_exp = 6'd40 + 6'(i); in_skip = 1'b0;
    end
    @(negedge clk);
    in_exp = 6'd63; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_max", 32'(out_max), 0);
    send_window(v, 1'b0);
    collect_window(v);

    // Async reset mid-EMIT at idx 4
    for (int i = 0; i < N; i++) ex[i] = EXP_W'(e1[i]);
    v = model(ex, '0, 2'd0);
    send_window(v, 1'b0);
    out_ready = 1'b1;
    begin
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (out_idx != 4'd4 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      chk("reach_idx4", 32'(out_idx), 4);
    end
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_idx", 32'(out_idx), 0);
    chk("async_rst_max", 32'(out_max), 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < N; i++) ex[i] = EXP_W'(N - i);
    v = model(ex, 9'b100000001, 2'd2);
    send_window(v, 1'b1);
    collect_window(v);

    // Random windows against the reference model
    for (int w = 0; w < 25; w++) begin
      logic [N-1:0] sk;
      for (int i = 0; i < N; i++) begin
        ex[i] = EXP_W'($urandom_range(0, 63));
        sk[i] = ($urandom_range(0, 3) == 0);
      end
      v = model(ex, sk, 2'(w % 3));
      send_window(v, 1'b1);
      collect_window(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end
endmodule
